sort3_stream: RTL
=================

SORT3_STREAM -- requirements
Module: sort3_stream

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low, sampled on the rising edge of clk.
REQ-003 The block SHALL have port in_valid, input, 1 bit: the a/b/c triple is offered.
REQ-004 The block SHALL have port in_ready, output, 1 bit: the block can accept a triple.
REQ-005 The block SHALL have ports a, b and c, input, 8 bits each: unsigned operands, captured when in_valid && in_ready.
REQ-006 The block SHALL have port out_valid, output, 1 bit: out_data holds a valid element.
REQ-007 The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the element.
REQ-008 The block SHALL have port out_data, output, 8 bits: the current sorted element.
REQ-009 The block SHALL have port out_last, output, 1 bit: high with the third element of a triple.

Function
REQ-010 The block SHALL use a state machine with states IDLE, CMP0, CMP1, CMP2 and EMIT.
REQ-011 In IDLE the block SHALL assert in_ready = 1; in all other states in_ready SHALL be 0.
REQ-012 In IDLE, on in_valid = 1 the block SHALL load r0 = a, r1 = b, r2 = c and go to CMP0; with in_valid = 0 it SHALL stay in IDLE.
REQ-013 The compare-and-swap sequence SHALL be:
- CMP0: swap r0 and r1 if r0 > r1.
- CMP1: swap r1 and r2 if r1 > r2.
- CMP2: swap r0 and r1 if r0 > r1.
- Each step takes one cycle, then the FSM advances to the next step.
REQ-014 After CMP2 the FSM SHALL enter EMIT with idx = 0.
REQ-015 Equal operands SHALL never be swapped; the comparison is strict and unsigned.
REQ-016 In EMIT the block SHALL drive out_valid = 1, out_data = r[idx], and out_last = (idx == 2).
REQ-017 On out_valid && out_ready the block SHALL increment idx; if idx == 2 it SHALL return to IDLE instead.
REQ-018 While out_valid = 1 and out_ready = 0, out_data, out_last and idx SHALL hold stable.
REQ-019 Latency: with a triple accepted at edge N and out_ready held at 1:
- the first element is valid after edge N+4;
- elements follow on consecutive cycles;
- in_ready returns 1 after edge N+7.
REQ-020 in_valid, a, b and c SHALL be ignored outside IDLE; there is no input overlap or buffering beyond one triple.
REQ-021 Outside EMIT the block SHALL drive out_valid = 0 and out_last = 0; out_data is don't-care but SHALL be driven from the registers (no X).
REQ-022 The block SHALL use only 8-bit unsigned registers; no widening is required.

Reset
REQ-023 On rst_n = 0 at a rising edge, the block SHALL set state = IDLE, idx = 0 and r0 = r1 = r2 = 8'h00, regardless of current state.
REQ-024 During and after reset the outputs SHALL be out_valid = 0, out_last = 0, out_data = 8'h00 and in_ready = 1 (from the first edge after rst_n = 0).
REQ-025 Reset asserted mid-sort or mid-emit SHALL abandon the triple; no partial output SHALL follow the deassertion of reset.

Configuration
REQ-026 With SORT3_DESCEND_EN defined, the block SHALL swap on r0 < r1 and r1 < r2 (strict), so elements are emitted largest first.
REQ-027 Without SORT3_DESCEND_EN, the block SHALL emit in ascending order as described in REQ-013.
REQ-028 Both builds SHALL have identical ports and timing.

Verification
REQ-029 Scenario: a=30, b=10, c=20, out_ready=1 -> out_data 10, 20, 30 on consecutive cycles, with out_last only on 30; first valid 4 cycles after acceptance.
REQ-030 Scenario: a=b=c=8'h55 -> three outputs of 8'h55; no change in register order; out_last on the third.
REQ-031 Scenario: a=255, b=0, c=128, with out_ready low for 3 cycles at the second element -> out_data=128 held stable with out_valid=1, then 255 with out_last.
REQ-032 Scenario: rst_n pulsed low during CMP1 -> out_valid stays 0 and in_ready=1 the next cycle; a new triple 3, 2, 1 then yields 1, 2, 3.
REQ-033 Scenario: in_valid held high with changing a/b/c during a sort -> only the triple accepted in IDLE is emitted.
REQ-034 Scenario (SORT3_DESCEND_EN build): a=30, b=10, c=20 -> 30, 20, 10.

Source files
------------

// File: rtl/sort3_stream.sv
// sort3_stream: accepts one unsigned 8-bit triple and streams it out sorted.
// The sort is three compare-and-swap steps, then the elements go out one at a time
// under valid/ready.
// Build option: define SORT3_DESCEND_EN to emit largest first. Ports and timing
// are the same in both builds.
// All outputs come straight from registers. Because of that, the first EMIT cycle
// fills the output register, and the first element becomes visible one edge later.
module sort3_stream (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] c,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last
);

  typedef enum logic [2:0] {
    StIdle,
    StCmp0,
    StCmp1,
    StCmp2,
    StEmit
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] r0_q, r0_d;
  logic [7:0] r1_q, r1_d;
  logic [7:0] r2_q, r2_d;
  logic [1:0] idx_q, idx_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic       out_last_q, out_last_d;
  logic [7:0] out_data_q, out_data_d;

  // True when the pair (x, y) must be swapped. The test is strict, so equal
  // operands never move.
  function automatic logic out_of_order(logic [7:0] x, logic [7:0] y);
`ifdef SORT3_DESCEND_EN
    return x < y;
`else
    return x > y;
`endif
  endfunction

  // Select the sorted element at position i.
  function automatic logic [7:0] pick(logic [1:0] i, logic [7:0] x0, logic [7:0] x1,
                                      logic [7:0] x2);
    logic [7:0] v;
    unique case (i)
      2'd0:    v = x0;
      2'd1:    v = x1;
      default: v = x2;
    endcase
    return v;
  endfunction

  // Next-state: load, three compare-and-swap steps, then emit under handshake.
  always_comb begin
    state_d     = state_q;
    r0_d        = r0_q;
    r1_d        = r1_q;
    r2_d        = r2_q;
    idx_d       = idx_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          r0_d       = a;
          r1_d       = b;
          r2_d       = c;
          in_ready_d = 1'b0;
          state_d    = StCmp0;
        end
      end
      StCmp0: begin
        if (out_of_order(r0_q, r1_q)) begin
          r0_d = r1_q;
          r1_d = r0_q;
        end
        state_d = StCmp1;
      end
      StCmp1: begin
        if (out_of_order(r1_q, r2_q)) begin
          r1_d = r2_q;
          r2_d = r1_q;
        end
        state_d = StCmp2;
      end
      StCmp2: begin
        if (out_of_order(r0_q, r1_q)) begin
          r0_d = r1_q;
          r1_d = r0_q;
        end
        idx_d   = 2'd0;
        state_d = StEmit;
      end
      StEmit: begin
        if (!out_valid_q) begin
          // Output register fill: present element idx.
          out_valid_d = 1'b1;
          out_data_d  = pick(idx_q, r0_q, r1_q, r2_q);
          out_last_d  = (idx_q == 2'd2);
        end else if (out_ready) begin
          if (idx_q == 2'd2) begin
            idx_d       = 2'd0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = StIdle;
          end else begin
            idx_d      = idx_q + 2'd1;
            out_data_d = pick(idx_q + 2'd1, r0_q, r1_q, r2_q);
            out_last_d = (idx_q == 2'd1);
          end
        end
        // A stall leaves idx, data and last untouched.
      end
      default: begin
        state_d     = StIdle;
        idx_d       = 2'd0;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase
  end

  // State and output registers. The synchronous reset drops any triple in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      r0_q        <= 8'h00;
      r1_q        <= 8'h00;
      r2_q        <= 8'h00;
      idx_q       <= 2'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      r0_q        <= r0_d;
      r1_q        <= r1_d;
      r2_q        <= r2_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;

endmodule
